// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results in per-FU FIFOs and grants up to CDB_WIDTH per cycle onto registered CDB lanes, in round-robin order.
// Ports:
//   clock, reset           posedge clock, asynchronous active-high reset
//   flush_i                squashes every buffered result and this cycle's grants
//   fu_*_i                 per-FU result fields, flattened as NUM_FU slices
//   fu_ready_o             per-FU "FIFO can accept this cycle"
//   cdb_valid_o, cdb_*_o   registered CDB lanes, flattened as CDB_WIDTH slices
module cdb_arbiter #(
    parameter  int XLEN      = 32,
    parameter  int PHYS_REGS = 128,
    parameter  int ROB_DEPTH = 64,
    parameter  int NUM_FU    = 4,
    parameter  int CDB_WIDTH = 2,
    parameter  int BUF_DEPTH = 2,
    localparam int PRF_W     = $clog2(PHYS_REGS),
    localparam int ROB_W     = $clog2(ROB_DEPTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush_i,
    input  logic [NUM_FU-1:0]           fu_valid_i,
    input  logic [NUM_FU*XLEN-1:0]      fu_value_i,
    input  logic [NUM_FU*PRF_W-1:0]     fu_dest_prf_i,
    input  logic [NUM_FU*ROB_W-1:0]     fu_rob_idx_i,
    input  logic [NUM_FU-1:0]           fu_exception_i,
    input  logic [NUM_FU-1:0]           fu_mispred_i,
    input  logic [NUM_FU*XLEN-1:0]      fu_jtype_value_i,
    input  logic [NUM_FU-1:0]           fu_is_jtype_i,
    output logic [NUM_FU-1:0]           fu_ready_o,
    output logic [CDB_WIDTH-1:0]        cdb_valid_o,
    output logic [CDB_WIDTH*XLEN-1:0]   cdb_value_o,
    output logic [CDB_WIDTH*PRF_W-1:0]  cdb_dest_prf_o,
    output logic [CDB_WIDTH*ROB_W-1:0]  cdb_rob_idx_o,
    output logic [CDB_WIDTH-1:0]        cdb_exception_o,
    output logic [CDB_WIDTH-1:0]        cdb_mispred_o,
    output logic [CDB_WIDTH*XLEN-1:0]   cdb_jtype_value_o,
    output logic [CDB_WIDTH-1:0]        cdb_is_jtype_o
);
    localparam int FU_W  = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
    localparam int PTR_W = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int ENT_W = 2 * XLEN + PRF_W + ROB_W + 3;

    logic [ENT_W-1:0]     r_mem [NUM_FU][BUF_DEPTH];
    logic [PTR_W-1:0]     r_head [NUM_FU];
    logic [PTR_W-1:0]     r_tail [NUM_FU];
    logic [CNT_W-1:0]     r_count [NUM_FU];
    logic [FU_W-1:0]      r_rr;
    logic [CDB_WIDTH-1:0] r_cdb_vld;
    logic [ENT_W-1:0]     r_cdb_ent [CDB_WIDTH];

    logic [ENT_W-1:0]     w_in_ent [NUM_FU];
    logic [ENT_W-1:0]     w_head_ent [NUM_FU];
    logic [NUM_FU-1:0]    w_push;
    logic [NUM_FU-1:0]    w_grant;
    logic [CDB_WIDTH-1:0] w_lane_vld;
    logic [FU_W-1:0]      w_lane_fu [CDB_WIDTH];
    logic [FU_W-1:0]      w_last;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return p == PTR_W'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        assign w_in_ent[f]   = {fu_value_i[f*XLEN +: XLEN], fu_dest_prf_i[f*PRF_W +: PRF_W],
                                fu_rob_idx_i[f*ROB_W +: ROB_W], fu_exception_i[f], fu_mispred_i[f],
                                fu_jtype_value_i[f*XLEN +: XLEN], fu_is_jtype_i[f]};
        assign w_head_ent[f] = r_mem[f][r_head[f]];
        // Ready depends only on the pre-edge count, so a same-cycle pop never raises it.
        assign fu_ready_o[f] = r_count[f] != CNT_W'(BUF_DEPTH);
        assign w_push[f]     = fu_valid_i[f] && fu_ready_o[f] && !flush_i;
    end

    for (genvar l = 0; l < CDB_WIDTH; l++) begin : g_lane
        assign {cdb_value_o[l*XLEN +: XLEN], cdb_dest_prf_o[l*PRF_W +: PRF_W],
                cdb_rob_idx_o[l*ROB_W +: ROB_W], cdb_exception_o[l], cdb_mispred_o[l],
                cdb_jtype_value_o[l*XLEN +: XLEN], cdb_is_jtype_o[l]} = r_cdb_ent[l];
    end
    assign cdb_valid_o = r_cdb_vld;

    // Scan FIFOs from the round-robin pointer; the n-th non-empty one takes lane n.
    always_comb begin
        int n;
        int t;
        logic [FU_W-1:0] f;
        n          = 0;
        t          = 0;
        f          = '0;
        w_grant    = '0;
        w_lane_vld = '0;
        w_last     = '0;
        for (int l = 0; l < CDB_WIDTH; l++) w_lane_fu[l] = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            t = int'(r_rr) + j;
            t = t >= NUM_FU ? t - NUM_FU : t;
            f = FU_W'(t);
            if (r_count[f] != '0 && n < CDB_WIDTH) begin
                for (int l = 0; l < CDB_WIDTH; l++) begin
                    if (l == n) begin
                        w_lane_vld[l] = 1'b1;
                        w_lane_fu[l]  = f;
                    end
                end
                w_grant[f] = 1'b1;
                w_last     = f;
                n          = n + 1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int f = 0; f < NUM_FU; f++) begin
                r_head[f]  <= '0;
                r_tail[f]  <= '0;
                r_count[f] <= '0;
            end
            for (int l = 0; l < CDB_WIDTH; l++) r_cdb_ent[l] <= '0;
            r_cdb_vld <= '0;
            r_rr      <= '0;
        end else if (flush_i) begin
            for (int f = 0; f < NUM_FU; f++) begin
                r_head[f]  <= '0;
                r_tail[f]  <= '0;
                r_count[f] <= '0;
            end
            for (int l = 0; l < CDB_WIDTH; l++) r_cdb_ent[l] <= '0;
            r_cdb_vld <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_push[f]) r_tail[f] <= nxt(r_tail[f]);
                if (w_grant[f]) r_head[f] <= nxt(r_head[f]);
                r_count[f] <= r_count[f] + CNT_W'(w_push[f]) - CNT_W'(w_grant[f]);
            end
            for (int l = 0; l < CDB_WIDTH; l++)
                r_cdb_ent[l] <= w_lane_vld[l] ? w_head_ent[w_lane_fu[l]] : '0;
            r_cdb_vld <= w_lane_vld;
            if (|w_grant) r_rr <= w_last == FU_W'(NUM_FU - 1) ? '0 : w_last + 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy is tracked solely by the counts.
    always_ff @(posedge clock) begin
        for (int f = 0; f < NUM_FU; f++)
            if (w_push[f]) r_mem[f][r_tail[f]] <= w_in_ent[f];
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (2-lane and 1-lane instances).
module tb_cdb_arbiter;
    logic         clock, reset, flush_i;
    logic [3:0]   fu_valid_i, fu_exception_i, fu_mispred_i, fu_is_jtype_i;
    logic [127:0] fu_value_i, fu_jtype_value_i;
    logic [27:0]  fu_dest_prf_i;
    logic [23:0]  fu_rob_idx_i;

    logic [3:0]   fu_ready_o;
    logic [1:0]   cdb_valid_o, cdb_exception_o, cdb_mispred_o, cdb_is_jtype_o;
    logic [63:0]  cdb_value_o, cdb_jtype_value_o;
    logic [13:0]  cdb_dest_prf_o;
    logic [11:0]  cdb_rob_idx_o;

    logic [3:0]   r1_ready;
    logic [0:0]   c1_valid, c1_exc, c1_mis, c1_isj;
    logic [31:0]  c1_value, c1_jval;
    logic [6:0]   c1_prf;
    logic [5:0]   c1_rob;

    int nerr = 0;
    int nchk = 0;

    cdb_arbiter u_dut (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .fu_valid_i(fu_valid_i), .fu_value_i(fu_value_i), .fu_dest_prf_i(fu_dest_prf_i),
        .fu_rob_idx_i(fu_rob_idx_i), .fu_exception_i(fu_exception_i), .fu_mispred_i(fu_mispred_i),
        .fu_jtype_value_i(fu_jtype_value_i), .fu_is_jtype_i(fu_is_jtype_i), .fu_ready_o(fu_ready_o),
        .cdb_valid_o(cdb_valid_o), .cdb_value_o(cdb_value_o), .cdb_dest_prf_o(cdb_dest_prf_o),
        .cdb_rob_idx_o(cdb_rob_idx_o), .cdb_exception_o(cdb_exception_o), .cdb_mispred_o(cdb_mispred_o),
        .cdb_jtype_value_o(cdb_jtype_value_o), .cdb_is_jtype_o(cdb_is_jtype_o)
    );

    cdb_arbiter #(.CDB_WIDTH(1)) u_dut1 (
        .clock(clock), .reset(reset), .flush_i(flush_i),
        .fu_valid_i(fu_valid_i), .fu_value_i(fu_value_i), .fu_dest_prf_i(fu_dest_prf_i),
        .fu_rob_idx_i(fu_rob_idx_i), .fu_exception_i(fu_exception_i), .fu_mispred_i(fu_mispred_i),
        .fu_jtype_value_i(fu_jtype_value_i), .fu_is_jtype_i(fu_is_jtype_i), .fu_ready_o(r1_ready),
        .cdb_valid_o(c1_valid), .cdb_value_o(c1_value), .cdb_dest_prf_o(c1_prf),
        .cdb_rob_idx_o(c1_rob), .cdb_exception_o(c1_exc), .cdb_mispred_o(c1_mis),
        .cdb_jtype_value_o(c1_jval), .cdb_is_jtype_o(c1_isj)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        flush_i          = 1'b0;
        fu_valid_i       = '0;
        fu_exception_i   = '0;
        fu_mispred_i     = '0;
        fu_is_jtype_i    = '0;
        fu_value_i       = '0;
        fu_jtype_value_i = '0;
        fu_dest_prf_i    = '0;
        fu_rob_idx_i     = '0;
    endtask

    task automatic set_fu(input int f, input logic [31:0] val, input logic [6:0] prf, input logic [5:0] rob);
        fu_valid_i[f]           = 1'b1;
        fu_value_i[f*32 +: 32]  = val;
        fu_dest_prf_i[f*7 +: 7] = prf;
        fu_rob_idx_i[f*6 +: 6]  = rob;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] pre, post;
        int seq [4];
        idle();
        reset = 1'b1;
        #1;
        chk("reset_ready", fu_ready_o, 4'hF);
        chk("reset_valid", cdb_valid_o, 2'b00);
        chk("reset_value", cdb_value_o, 64'h0);
        chk("reset_rob", cdb_rob_idx_o, 12'h0);
        tick();
        reset = 1'b0;

        // Single ALU result: pushed on one edge, on the CDB after the next.
        set_fu(0, 32'h5, 7'd7, 6'd3);
        tick();
        idle();
        chk("single_nobypass", cdb_valid_o, 2'b00);
        tick();
        chk("single_valid", cdb_valid_o, 2'b01);
        chk("single_value", cdb_value_o[31:0], 32'h5);
        chk("single_prf", cdb_dest_prf_o[6:0], 7'd7);
        chk("single_rob", cdb_rob_idx_o[5:0], 6'd3);
        tick();
        chk("single_drain", cdb_valid_o, 2'b00);

        // All four FUs at once from rr_ptr=0.
        do_reset();
        for (int f = 0; f < 4; f++) set_fu(f, 32'(100 + f), 7'(f), 6'(10 + f));
        tick();
        idle();
        chk("all4_nobypass", cdb_valid_o, 2'b00);
        tick();
        chk("all4_c1_valid", cdb_valid_o, 2'b11);
        chk("all4_c1_lanes", cdb_rob_idx_o, {6'd11, 6'd10});
        chk("all4_c1_value", cdb_value_o, {32'd101, 32'd100});
        tick();
        chk("all4_c2_valid", cdb_valid_o, 2'b11);
        chk("all4_c2_lanes", cdb_rob_idx_o, {6'd13, 6'd12});
        tick();
        chk("all4_drain", cdb_valid_o, 2'b00);
        set_fu(3, 32'd3, 7'd3, 6'd33);
        set_fu(0, 32'd0, 7'd0, 6'd30);
        tick();
        idle();
        tick();
        chk("all4_rr0_lanes", cdb_rob_idx_o, {6'd33, 6'd30});

        // FU1 streaming one result per cycle.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_fu(1, 32'(i), 7'd1, 6'(20 + i));
            tick();
            chk("stream_ready", fu_ready_o[1], 1'b1);
            if (i > 0) begin
                chk("stream_valid", cdb_valid_o, 2'b01);
                chk("stream_rob", cdb_rob_idx_o[5:0], 6'(20 + i - 1));
            end
        end
        idle();
        tick();
        chk("stream_last", cdb_rob_idx_o[5:0], 6'd25);
        tick();
        chk("stream_drain", cdb_valid_o, 2'b00);

        // Single-lane instance, every FU always valid: FIFOs fill, grants rotate.
        do_reset();
        for (int f = 0; f < 4; f++) seq[f] = 0;
        pre = 4'hF;
        for (int k = 1; k <= 13; k++) begin
            for (int f = 0; f < 4; f++) set_fu(f, 32'(f * 100 + seq[f]), 7'(f), 6'(f * 8 + seq[f]));
            tick();
            for (int f = 0; f < 4; f++) if (pre[f]) seq[f]++;
            post = (k == 1) ? 4'hF : 4'(1 << ((k - 2) % 4));
            chk("w1_ready", r1_ready, post);
            if (k >= 2) begin
                chk("w1_valid", c1_valid, 1'b1);
                chk("w1_rob", c1_rob, 6'(8 * ((k - 2) % 4) + (k - 2) / 4));
            end
            pre = post;
        end

        // Branch result fields pass through unchanged.
        do_reset();
        set_fu(3, 32'hAB, 7'd9, 6'd5);
        fu_exception_i[3]          = 1'b1;
        fu_mispred_i[3]            = 1'b1;
        fu_is_jtype_i[3]           = 1'b1;
        fu_jtype_value_i[127:96]   = 32'h104;
        tick();
        idle();
        tick();
        chk("br_valid", cdb_valid_o, 2'b01);
        chk("br_value", cdb_value_o[31:0], 32'hAB);
        chk("br_flags", {cdb_exception_o[0], cdb_mispred_o[0], cdb_is_jtype_o[0]}, 3'b111);
        chk("br_jval", cdb_jtype_value_o, {32'h0, 32'h104});
        chk("br_prf_rob", {cdb_dest_prf_o[6:0], cdb_rob_idx_o[5:0]}, {7'd9, 6'd5});
        chk("br_lane1_flags", {cdb_exception_o[1], cdb_mispred_o[1], cdb_is_jtype_o[1]}, 3'b000);

        // Flush with three entries buffered and a new FU0 result in the same cycle.
        do_reset();
        for (int f = 0; f < 3; f++) set_fu(f, 32'(f), 7'(f), 6'(1 + f));
        tick();
        idle();
        set_fu(0, 32'h40, 7'd4, 6'd40);
        flush_i = 1'b1;
        tick();
        idle();
        chk("flush_valid", cdb_valid_o, 2'b00);
        chk("flush_ready", fu_ready_o, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_quiet", cdb_valid_o, 2'b00);
            chk("flush_quiet1", c1_valid, 1'b0);
        end

        // Reset asserted mid-burst takes effect without a clock edge.
        do_reset();
        for (int f = 0; f < 4; f++) set_fu(f, 32'(f + 1), 7'(f), 6'(1 + f));
        tick();
        idle();
        tick();
        chk("burst_valid", cdb_valid_o, 2'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", cdb_valid_o, 2'b00);
        chk("arst_value", cdb_value_o, 64'h0);
        chk("arst_rob", cdb_rob_idx_o, 12'h0);
        chk("arst_ready1", r1_ready, 4'hF);
        reset = 1'b0;
        tick();
        chk("arst_cleared", cdb_valid_o, 2'b00);
        set_fu(1, 32'd1, 7'd1, 6'd51);
        set_fu(3, 32'd3, 7'd3, 6'd53);
        tick();
        idle();
        tick();
        chk("arst_rr0_lanes", cdb_rob_idx_o, {6'd53, 6'd51});

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
